// File: rtl/sseg_scan_controller_pkg.sv
// Shared constants for the seven-segment scan controller.
// Purpose : digit geometry and register widths used by the top and the bench.
// Ports   : none (package).
package sseg_scan_controller_pkg;
    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int SEL_W      = 3;
    localparam int CNT_W      = 4;
endpackage

// File: rtl/sseg_scan_controller_refresh_timer.sv
// Dwell timer for the display scan.
// Purpose : free-running mod-DIV counter. It flags the last cycle of each dwell
//           with tc and exposes the current count for the blanking compare.
// Ports   : clk, reset (sync, active-high)
//           count - current dwell position, 0..DIV-1
//           tc    - high while count == DIV-1
module sseg_scan_controller_refresh_timer #(
    parameter int DIV = 100000,
    parameter int TW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic [TW-1:0] count,
    output logic          tc
);
    assign tc = (count == TW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tc) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end
endmodule

// File: rtl/sseg_scan_controller.sv
// Time-multiplexing controller for an 8-digit seven-segment display.
// Purpose : holds eight hex digits and their DPs, loaded by shift-in (push) or
//           by addressed write, and scans them round-robin into a single-digit
//           driver, with blanking at the start of each dwell and optional
//           suppression of digits beyond the valid count.
// Ports   : clk, reset (sync, active-high)
//           push_valid/push_data/push_dp - shift a character in at digit 0
//           wr_en/wr_addr/wr_data/wr_dp   - direct write to one digit
//           clear                         - zero all digits and the count
//           blank_leading                 - keep digits at index >= count dark
//           hex_number, digit_sel, dp_out, digit_en - registered driver outputs
//           count                         - number of valid digits, 0..8
// Update priority within a cycle: clear > push > write; lower ones are dropped.
module sseg_scan_controller
    import sseg_scan_controller_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_valid,
    input  logic [DIGIT_W-1:0] push_data,
    input  logic               push_dp,
    input  logic               wr_en,
    input  logic [SEL_W-1:0]   wr_addr,
    input  logic [DIGIT_W-1:0] wr_data,
    input  logic               wr_dp,
    input  logic               clear,
    input  logic               blank_leading,
    output logic [DIGIT_W-1:0] hex_number,
    output logic [SEL_W-1:0]   digit_sel,
    output logic               dp_out,
    output logic               digit_en,
    output logic [CNT_W-1:0]   count
);
    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [TW-1:0]      dwell;
    logic               tc;
    logic [DIGIT_W-1:0] digits [NUM_DIGITS];
    logic               dps    [NUM_DIGITS];

    logic [SEL_W-1:0]   sel_next;
    logic               blank_next;
    logic               lead_dark;
    logic [CNT_W-1:0]   wr_count;
    logic [CNT_W-1:0]   count_next;
    logic [31:0]        dwell_wide;

    sseg_scan_controller_refresh_timer #(
        .DIV (REFRESH_DIV),
        .TW  (TW)
    ) u_refresh_timer (
        .clk   (clk),
        .reset (reset),
        .count (dwell),
        .tc    (tc)
    );

    // The output registers are loaded from the values the scan will hold after
    // this edge, so hex/dp/en always line up with the digit_sel driven beside
    // them. Storage is read pre-update, giving one cycle of write latency.
    always_comb begin
        dwell_wide = 32'(dwell);
        sel_next   = tc ? digit_sel + SEL_W'(1) : digit_sel;
        if (tc) begin
            blank_next = (BLANK_CYCLES > 0);
        end else begin
            blank_next = (dwell_wide + 32'd1) < 32'(BLANK_CYCLES);
        end
        lead_dark = blank_leading && ({1'b0, sel_next} >= count);

        wr_count   = {1'b0, wr_addr} + CNT_W'(1);
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (push_valid) begin
            count_next = (count >= CNT_W'(NUM_DIGITS)) ? CNT_W'(NUM_DIGITS) : count + CNT_W'(1);
        end else if (wr_en) begin
            count_next = (wr_count > count) ? wr_count : count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits[i] <= '0;
                dps[i]    <= 1'b0;
            end
            count      <= '0;
            digit_sel  <= '0;
            hex_number <= '0;
            dp_out     <= 1'b0;
            digit_en   <= 1'b0;
        end else begin
            if (clear) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digits[i] <= '0;
                    dps[i]    <= 1'b0;
                end
            end else if (push_valid) begin
                for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                    digits[i] <= digits[i-1];
                    dps[i]    <= dps[i-1];
                end
                digits[0] <= push_data;
                dps[0]    <= push_dp;
            end else if (wr_en) begin
                digits[wr_addr] <= wr_data;
                dps[wr_addr]    <= wr_dp;
            end
            count      <= count_next;
            digit_sel  <= sel_next;
            hex_number <= digits[sel_next];
            dp_out     <= dps[sel_next];
            digit_en   <= !blank_next && !lead_dark;
        end
    end
endmodule

// File: tb/tb_sseg_scan_controller.sv
// Self-checking bench for sseg_scan_controller with REFRESH_DIV=8, BLANK_CYCLES=2.
// The reference model tracks time since reset and derives the scan position as
// (t / DIV) % 8 and t % DIV; storage is kept as plain arrays updated by the
// clear/push/write rules, and the display side reads the previous cycle's copy.
module tb_sseg_scan_controller;
    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push_valid = 1'b0;
    logic [3:0] push_data = '0;
    logic       push_dp = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       wr_dp = 1'b0;
    logic       clear = 1'b0;
    logic       blank_leading = 1'b1;
    logic [3:0] hex_number;
    logic [2:0] digit_sel;
    logic       dp_out;
    logic       digit_en;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    // Model state
    int         t = 0;
    logic [3:0] m_dig [8];
    logic       m_dp  [8];
    int         m_count = 0;

    // Expected packed as {sel[3], hex[4], dp, en, count[4]}
    logic [12:0] exp_q[$];

    sseg_scan_controller #(
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push_valid    (push_valid),
        .push_data     (push_data),
        .push_dp       (push_dp),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_dp         (wr_dp),
        .clear         (clear),
        .blank_leading (blank_leading),
        .hex_number    (hex_number),
        .digit_sel     (digit_sel),
        .dp_out        (dp_out),
        .digit_en      (digit_en),
        .count         (count)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs held this cycle,
    // queue the expected outputs, then compare 1 time unit after the edge.
    task automatic step();
        logic [3:0] old_dig [8];
        logic       old_dp  [8];
        int         old_count;
        int         sel, pos;
        logic       en;
        logic [12:0] e, g;
        @(posedge clk);
        if (reset) begin
            t = 0;
            m_count = 0;
            for (int i = 0; i < 8; i++) begin
                m_dig[i] = '0;
                m_dp[i]  = 1'b0;
            end
            exp_q.push_back(13'd0);
        end else begin
            old_dig = m_dig;
            old_dp  = m_dp;
            old_count = m_count;
            t++;
            if (clear) begin
                for (int i = 0; i < 8; i++) begin
                    m_dig[i] = '0;
                    m_dp[i]  = 1'b0;
                end
                m_count = 0;
            end else if (push_valid) begin
                for (int i = 7; i > 0; i--) begin
                    m_dig[i] = m_dig[i-1];
                    m_dp[i]  = m_dp[i-1];
                end
                m_dig[0] = push_data;
                m_dp[0]  = push_dp;
                m_count = (m_count + 1 > 8) ? 8 : m_count + 1;
            end else if (wr_en) begin
                m_dig[wr_addr] = wr_data;
                m_dp[wr_addr]  = wr_dp;
                if (int'(wr_addr) + 1 > m_count) m_count = int'(wr_addr) + 1;
            end
            sel = (t / DIV) % 8;
            pos = t % DIV;
            en  = (pos >= BLANK) && !(blank_leading && sel >= old_count);
            exp_q.push_back({3'(sel), old_dig[sel], old_dp[sel], en, 4'(m_count)});
        end
        #1;
        e = exp_q.pop_front();
        g = {digit_sel, hex_number, dp_out, digit_en, count};
        check_val("digit_sel",  32'(g[12:10]), 32'(e[12:10]));
        check_val("hex_number", 32'(g[9:6]),   32'(e[9:6]));
        check_val("dp_out",     32'(g[5]),     32'(e[5]));
        check_val("digit_en",   32'(g[4]),     32'(e[4]));
        check_val("count",      32'(g[3:0]),   32'(e[3:0]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_push(input logic [3:0] v, input logic p);
        push_valid = 1'b1; push_data = v; push_dp = p;
        step();
        push_valid = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [3:0] d, input logic p);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_dig[i] = '0;
            m_dp[i]  = 1'b0;
        end
        // Reset then idle with and without leading blanking
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        blank_leading = 1'b1;
        idle(64);
        blank_leading = 1'b0;
        idle(64);

        // Push 3, A, 5 and scan with leading blanking
        blank_leading = 1'b1;
        do_push(4'h3, 1'b0);
        do_push(4'hA, 1'b1);
        do_push(4'h5, 1'b0);
        check_val("count_three", 32'(count), 32'd3);
        idle(64);

        // Saturating push of ten values
        for (int v = 0; v < 10; v++) do_push(4'(v), v[0]);
        check_val("count_sat", 32'(count), 32'd8);
        blank_leading = 1'b0;
        idle(64);

        // Clear + push + write in one cycle: only the clear lands
        clear = 1'b1; push_valid = 1'b1; push_data = 4'hF; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 4'hC;
        step();
        clear = 1'b0; push_valid = 1'b0; wr_en = 1'b0;
        check_val("count_clear", 32'(count), 32'd0);
        idle(64);

        // Two pushes then a write to digit 5 extends the count to 6
        blank_leading = 1'b1;
        do_push(4'h1, 1'b0);
        do_push(4'h2, 1'b0);
        do_write(3'd5, 4'hE, 1'b1);
        check_val("count_write", 32'(count), 32'd6);
        idle(64);

        // Fill, then reset for one cycle mid-dwell on digit 4
        for (int v = 0; v < 8; v++) do_push(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 64 && !(((t + 1) / DIV) % 8 == 4 && (t + 1) % DIV == 3); k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("reset_sel", 32'(digit_sel), 32'd0);
        blank_leading = 1'b0;
        idle(64);

        // Randomised traffic
        for (int k = 0; k < 1500; k++) begin
            clear      = ($urandom_range(0, 99) < 3);
            push_valid = ($urandom_range(0, 3) == 0);
            push_data  = 4'($urandom_range(0, 15));
            push_dp    = 1'($urandom_range(0, 1));
            wr_en      = ($urandom_range(0, 4) == 0);
            wr_addr    = 3'($urandom_range(0, 7));
            wr_data    = 4'($urandom_range(0, 15));
            wr_dp      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) blank_leading = ~blank_leading;
            reset      = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; clear = 1'b0; push_valid = 1'b0; wr_en = 1'b0;
        idle(16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
